// File: rtl/flip_arb_pkg.sv
// Shared types and helpers for the flip arbiter: FSM state encoding,
// default sizes and a width-agnostic bit-reverse function.
package flip_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FLIP = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_WIDTH   = 8;
   localparam int DEF_ID_W    = 2;
   localparam int MAX_WIDTH   = 64;

   // Reverses the low w bits of d; bits at and above w come back as zero.
   function automatic logic [MAX_WIDTH-1:0] bit_rev(input logic [MAX_WIDTH-1:0] d,
                                                    input int w);
      logic [MAX_WIDTH-1:0] r;
      r = '0;
      for (int k = 0; k < MAX_WIDTH; k++) begin
         if (k < w) r[k] = d[w-1-k];
      end
      return r;
   endfunction

endpackage

// File: rtl/flip_arbiter_rr_pick.sv
// Combinational winner selection for the flip arbiter. Round-robin from
// ptr_i+1 by default; FLIP_ARB_FIXED_PRIO_EN selects lowest-index-wins.
module flip_arbiter_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               any_o
);

`ifdef FLIP_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr_i;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any_o && req_i[i]) begin
            any_o    = 1'b1;
            idx_o    = ID_W'(i);
            gnt_o[i] = 1'b1;
         end
      end
   end
`else
   int cand;

   // Candidate index wraps mod NUM_REQ so non-power-of-2 counts never overrun.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = (int'(ptr_i) + off) % NUM_REQ;
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            idx_o       = ID_W'(cand);
            gnt_o[cand] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/flip_arbiter.sv
// Shares one registered bit-reversal stage between NUM_REQ requesters.
// Arbitration mode is chosen inside rr_pick by FLIP_ARB_FIXED_PRIO_EN.
//
// state | meaning
// IDLE  | waiting for a request; req_ready one-hot to the winner
// FLIP  | captured word is reversed; dwells LATENCY cycles
// RESP  | rsp_valid high, word and id held until rsp_ready
module flip_arbiter
   import flip_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int LATENCY = 1,
   parameter int ID_W    = DEF_ID_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   output logic [WIDTH-1:0]         rsp_data,
   output logic [ID_W-1:0]          rsp_id,
   input  logic                     rsp_ready,
   output logic                     busy
);

   localparam logic [2:0] LAT_LAST = 3'(LATENCY - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [2:0]         lat_q, lat_d;

   logic [NUM_REQ-1:0] win_gnt;
   logic [ID_W-1:0]    win_idx;
   logic               win_any;
   logic [WIDTH-1:0]   data_rev;

   flip_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (win_gnt),
      .idx_o (win_idx),
      .any_o (win_any)
   );

   assign data_rev = WIDTH'(bit_rev(MAX_WIDTH'(data_q), WIDTH));

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      id_d      = id_q;
      ptr_d     = ptr_q;
      lat_d     = lat_q;
      req_ready = '0;
      rsp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Gated by rst_n so no requester sees an accept that reset discards.
            req_ready = win_gnt & {NUM_REQ{rst_n}};
            if (win_any) begin
               data_d  = req_data[int'(win_idx)*WIDTH +: WIDTH];
               id_d    = win_idx;
               ptr_d   = win_idx;
               lat_d   = '0;
               state_d = ST_FLIP;
            end
         end
         ST_FLIP: begin
            lat_d = 3'(lat_q + 3'd1);
            if (lat_q == 3'd0) data_d = data_rev;
            if (lat_q == LAT_LAST) state_d = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         id_q    <= '0;
         ptr_q   <= ID_W'(NUM_REQ - 1);
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         lat_q   <= lat_d;
      end
   end

   assign rsp_data = data_q;
   assign rsp_id   = id_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_flip_arbiter.sv
// Directed-vector bench for flip_arbiter: a LATENCY=1 instance for the main
// checks and a LATENCY=3 instance for the longer flip dwell.
module tb_flip_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid, req_ready;
   logic [31:0] req_data;
   logic        rsp_valid, rsp_ready, busy;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_id;

   logic [3:0]  req_valid3, req_ready3;
   logic [31:0] req_data3;
   logic        rsp_valid3, rsp_ready3, busy3;
   logic [7:0]  rsp_data3;
   logic [1:0]  rsp_id3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   flip_arbiter #(.NUM_REQ(4), .WIDTH(8), .LATENCY(1), .ID_W(2)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   flip_arbiter #(.NUM_REQ(4), .WIDTH(8), .LATENCY(3), .ID_W(2)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid3),
      .req_data  (req_data3),
      .req_ready (req_ready3),
      .rsp_valid (rsp_valid3),
      .rsp_data  (rsp_data3),
      .rsp_id    (rsp_id3),
      .rsp_ready (rsp_ready3),
      .busy      (busy3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on the LATENCY=1 instance, starting in IDLE.
   task automatic txn(input int exp_id, input logic [7:0] exp_d, input int stall);
      #1;
      chk("grant", 32'(req_ready), 32'(4'b0001 << exp_id));
      rsp_ready = (stall == 0);
      tick();
      chk("flip_busy", 32'(busy), 32'd1);
      chk("flip_ready", 32'(req_ready), 32'd0);
      tick();
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_data", 32'(rsp_data), 32'(exp_d));
      chk("rsp_id", 32'(rsp_id), 32'(exp_id));
      for (int s = 0; s < stall; s++) begin
         tick();
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_data", 32'(rsp_data), 32'(exp_d));
         chk("hold_id", 32'(rsp_id), 32'(exp_id));
         chk("hold_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      chk("done_valid", 32'(rsp_valid), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = '0;
      req_data   = '0;
      rsp_ready  = 1'b0;
      req_valid3 = '0;
      req_data3  = '0;
      rsp_ready3 = 1'b0;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_data", 32'(rsp_data), 32'd0);
      chk("rst_id", 32'(rsp_id), 32'd0);
      rst_n = 1'b1;

      // Single request from requester 0
      req_valid = 4'b0001;
      req_data  = 32'h0000_0001;
      txn(0, 8'h80, 0);
      req_valid = '0;

`ifdef FLIP_ARB_FIXED_PRIO_EN
      req_data  = {8'h01, 8'hC3, 8'h0F, 8'hA0};
      req_valid = 4'b0110;
      for (int t = 0; t < 3; t++) txn(1, 8'hF0, 0);
      req_valid = '0;
`else
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req_data  = {8'h01, 8'hC3, 8'h0F, 8'hA0};
      req_valid = 4'b1111;
      txn(0, 8'h05, 0);
      txn(1, 8'hF0, 0);
      txn(2, 8'hC3, 0);
      txn(3, 8'h80, 0);
      txn(0, 8'h05, 0);
      req_valid = '0;
`endif

      // Backpressure: consumer stalls 5 cycles in RESP
      req_valid = 4'b1000;
      req_data[31:24] = 8'h01;
      txn(3, 8'h80, 5);
      req_valid = '0;

      // LATENCY=3: requester 2 with 8'h12 -> 8'h48
      req_data3[23:16] = 8'h12;
      req_valid3 = 4'b0100;
      #1;
      chk("l3_grant", 32'(req_ready3), 32'b0100);
      tick();
      req_valid3 = '0;
      chk("l3_busy_t1", 32'(busy3), 32'd1);
      chk("l3_valid_t1", 32'(rsp_valid3), 32'd0);
      tick();
      chk("l3_valid_t2", 32'(rsp_valid3), 32'd0);
      tick();
      chk("l3_valid_t3", 32'(rsp_valid3), 32'd0);
      chk("l3_busy_t3", 32'(busy3), 32'd1);
      tick();
      chk("l3_valid_t4", 32'(rsp_valid3), 32'd1);
      chk("l3_data", 32'(rsp_data3), 32'h48);
      chk("l3_id", 32'(rsp_id3), 32'd2);
      rsp_ready3 = 1'b1;
      tick();
      chk("l3_done_busy", 32'(busy3), 32'd0);
      chk("l3_done_valid", 32'(rsp_valid3), 32'd0);
      rsp_ready3 = 1'b0;

      // Reset while in FLIP
      rsp_ready = 1'b0;
      req_data[23:16] = 8'hC3;
      req_valid = 4'b0100;
      tick();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req_valid = 4'b0010;
      chk("rst_flip_valid", 32'(rsp_valid), 32'd0);
      chk("rst_flip_busy", 32'(busy), 32'd0);
      chk("rst_flip_data", 32'(rsp_data), 32'd0);

      // Reset while in RESP
      tick();
      req_valid = '0;
      tick();
      chk("pre_rst_rsp", 32'(rsp_valid), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_busy", 32'(busy), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      req_valid = 4'b1111;
      #1;
      chk("rst_ptr_grant", 32'(req_ready), 32'b0001);
      req_valid = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
